// File: rtl/ets_pkg.sv
// Shared definitions for the ETS frame reader: widths, default frame length
// and controller state encoding.
package ets_pkg;

  localparam int unsigned DataW     = 32;
  localparam int unsigned AddrW     = 10;
  localparam int unsigned CntW      = 16;
  localparam int unsigned HoldW     = 16;
  localparam int unsigned MaxTapDef = 616;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StFinish,
    StHold
  } ets_state_e;

endpackage

// File: rtl/ets_skid_fifo.sv
// Two-entry FIFO that decouples buffer read latency from downstream stalls.
module ets_skid_fifo
  import ets_pkg::*;
#(
  parameter int unsigned Width = DataW
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [Width-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= ~r_wptr;
      end
      if (pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = r_mem[r_rptr];
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/ets_frame_reader.sv
// Reads one MAX_TAP-word frame from a ready buffer and streams it out with
// backpressure, then pulses r_finish and waits HOLDOFF cycles before rearming.
module ets_frame_reader
  import ets_pkg::*;
#(
  parameter int unsigned MAX_TAP = MaxTapDef,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             r_valid,
  output logic             r_occur,
  output logic [AddrW-1:0] raddr,
  input  logic [DataW-1:0] rdata,
  output logic             r_finish,
  output logic [DataW-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic [CntW-1:0]  frame_cnt
);

  localparam logic [AddrW-1:0] LastAddr    = AddrW'(MAX_TAP - 1);
  localparam int unsigned      HoldLastInt = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;
  localparam logic [HoldW-1:0] HoldLast    = HoldW'(HoldLastInt);

  ets_state_e       r_state;
  ets_state_e       w_state_next;
  logic [AddrW-1:0] r_raddr;
  logic [AddrW-1:0] r_oidx;
  logic             r_inflight;
  logic [CntW-1:0]  r_frame_cnt;
  logic [HoldW-1:0] r_hold_cnt;

  logic             w_occur;
  logic             w_start;
  logic             w_pop;
  logic             w_room;
  logic [2:0]       w_occ;
  logic [1:0]       w_count;
  logic             w_full;
  logic             w_empty;
  logic [DataW-1:0] w_head;

  ets_skid_fifo #(
    .Width (DataW)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .push    (r_inflight),
    .wdata   (rdata),
    .pop     (w_pop),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_pop = !w_empty && m_tready;

  // Occupancy as it will stand after this cycle's pop, so that a steady
  // stream with m_tready high still issues one strobe per cycle.
  assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_room = !(w_full && !w_pop) && (w_occ < 3'd2);

  assign w_start = (r_state == StIdle) && en && r_valid;

  always_comb begin
    w_state_next = r_state;
    w_occur      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (en && r_valid) begin
          w_state_next = StRead;
        end
      end
      StRead: begin
        w_occur = w_room;
        if (w_room && (r_raddr == LastAddr)) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && m_tlast) begin
          w_state_next = StFinish;
        end
      end
      StFinish: begin
        w_state_next = (HOLDOFF == 0) ? StIdle : StHold;
      end
      StHold: begin
        if (r_hold_cnt == HoldLast) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_raddr     <= '0;
      r_oidx      <= '0;
      r_inflight  <= 1'b0;
      r_frame_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_occur;

      // The final strobe leaves raddr parked on the last word.
      if (w_start) begin
        r_raddr <= '0;
      end else if (w_occur && (r_raddr != LastAddr)) begin
        r_raddr <= r_raddr + AddrW'(1);
      end

      if (w_start) begin
        r_oidx <= '0;
      end else if (w_pop) begin
        r_oidx <= m_tlast ? '0 : r_oidx + AddrW'(1);
      end

      if (r_state == StFinish) begin
        r_frame_cnt <= r_frame_cnt + CntW'(1);
        r_hold_cnt  <= '0;
      end else if (r_state == StHold) begin
        r_hold_cnt <= r_hold_cnt + HoldW'(1);
      end
    end
  end

  assign r_occur   = w_occur;
  assign raddr     = r_raddr;
  assign r_finish  = (r_state == StFinish);
  assign m_tvalid  = !w_empty;
  assign m_tdata   = w_head;
  assign m_tlast   = !w_empty && (r_oidx == LastAddr);
  assign busy      = (r_state == StRead) || (r_state == StDrain) || (r_state == StFinish);
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_ets_frame_reader.sv
// Randomised bench for ets_frame_reader: buffer model, frame-level reference
// model and a single negedge compare process.
`timescale 1ns/1ps
module tb_ets_frame_reader;

  localparam int unsigned MAX_TAP = 8;
  localparam int unsigned HOLDOFF = 4;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        r_valid;
  logic        r_occur;
  logic [9:0]  raddr;
  logic [31:0] rdata = '0;
  logic        r_finish;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 sys_clk = ~sys_clk;

  ets_frame_reader #(
    .MAX_TAP (MAX_TAP),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .en        (en),
    .r_valid   (r_valid),
    .r_occur   (r_occur),
    .raddr     (raddr),
    .rdata     (rdata),
    .r_finish  (r_finish),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // Written only by the compare process.
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tmo_seen = 0;
  logic [15:0] frame_tag = '0;
  logic [15:0] fin_count = '0;
  int          fin_total = 0;
  int          frame_no = 0;
  bit          in_frame = 0;
  bit          start_next = 0;
  int          wait_cnt = 0;
  int          exp_addr = 0;
  int          oidx = 0;
  int          strobes = 0;
  int          xfers = 0;
  bit          fin_pending = 0;
  bit          fin_next;
  bit          stall_prev = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] cap_data [MAX_TAP];
  int          cap_cyc [MAX_TAP];
  int          first_busy_cyc = 0;
  int          finish_cyc = 0;
  bit          have_finish = 0;
  bit          chk_cnt1 = 0;
  bit          chk_wrap = 0;

  // Written only by the stimulus process.
  bit          gap_test = 0;
  bit          wrap_armed = 0;
  logic [15:0] cnt_offset = '0;
  int          n_tmo = 0;

  // Frame buffer: word at address a of frame tag t is {t,16'h0} + 0x100 + a.
  always @(posedge sys_clk) begin
    if (r_occur) rdata <= {frame_tag, 16'h0} + 32'h100 + 32'(raddr);
  end

  function automatic logic [31:0] exp_word(input logic [15:0] tag, input int idx);
    return {tag, 16'h0} + 32'h100 + 32'(idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge sys_clk) begin
    cyc++;
    chk("wait_bound", 32'(n_tmo - tmo_seen), 32'd0);
    tmo_seen = n_tmo;
    if (!reset_n) begin
      chk("rst_ctrl", {27'd0, r_occur, r_finish, m_tvalid, m_tlast, busy}, 32'd0);
      chk("rst_raddr", 32'(raddr), 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      in_frame = 0; start_next = 0; wait_cnt = 0; fin_count = '0; fin_pending = 0;
      stall_prev = 0; strobes = 0; xfers = 0; oidx = 0; exp_addr = 0;
      chk_cnt1 = 0; chk_wrap = 0; have_finish = 0;
    end else begin
      if (start_next) begin
        in_frame = 1; exp_addr = 0; oidx = 0; strobes = 0; xfers = 0;
        first_busy_cyc = cyc;
        // r_finish at cycle F: HOLDOFF hold cycles, one idle cycle, READ at F+6.
        if (gap_test && have_finish) chk("holdoff_gap", 32'(cyc - finish_cyc), 32'd6);
      end
      start_next = 0;
      chk("busy", 32'(busy), 32'(in_frame));
      chk("occur_outside_frame", 32'(r_occur && !in_frame), 32'd0);
      if (r_occur) begin
        chk("raddr", 32'(raddr), 32'(exp_addr));
        chk("raddr_range", 32'(raddr < 10'(MAX_TAP)), 32'd1);
        exp_addr++;
        strobes++;
      end
      if (stall_prev) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", m_tdata, prev_data);
        chk("hold_last", 32'(m_tlast), 32'(prev_last));
      end
      if (m_tvalid) begin
        chk("tdata", m_tdata, exp_word(frame_tag, oidx));
        chk("tlast", 32'(m_tlast), 32'(oidx == MAX_TAP - 1));
      end else begin
        chk("tlast_idle", 32'(m_tlast), 32'd0);
      end
      fin_next = 0;
      if (m_tvalid && m_tready) begin
        if (frame_no == 0 && oidx < MAX_TAP) begin
          cap_data[oidx] = m_tdata;
          cap_cyc[oidx] = cyc;
        end
        if (oidx == MAX_TAP - 1) fin_next = 1;
        oidx++;
        xfers++;
      end
      stall_prev = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
      chk("outstanding_le2", 32'((strobes - xfers) <= 2), 32'd1);
      chk("r_finish", 32'(r_finish), 32'(fin_pending));
      chk("frame_cnt", 32'(frame_cnt), 32'(16'(fin_count + cnt_offset)));
      if (chk_cnt1) chk("frame_cnt_first", 32'(frame_cnt), 32'd1);
      if (chk_wrap) chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
      chk_cnt1 = 0;
      chk_wrap = 0;
      if (r_finish) begin
        if (frame_no == 0) begin
          for (int i = 0; i < MAX_TAP; i++) begin
            chk("first_frame_word", cap_data[i], 32'h100 + 32'(i));
            chk("first_frame_consecutive", 32'(cap_cyc[i] - cap_cyc[0]), 32'(i));
          end
          chk("first_valid_latency", 32'(cap_cyc[0] - first_busy_cyc), 32'd2);
          chk_cnt1 = 1;
        end
        if (wrap_armed) chk_wrap = 1;
        fin_count++;
        fin_total++;
        frame_no++;
        frame_tag++;
        in_frame = 0;
        wait_cnt = HOLDOFF;
        have_finish = 1;
        finish_cyc = cyc;
      end else if (!in_frame) begin
        if (wait_cnt > 0) wait_cnt--;
        else if (en && r_valid) start_next = 1;
      end
      fin_pending = fin_next;
    end
  end

  task automatic wait_finish(input int budget);
    int  start_total = fin_total;
    bit  ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (fin_total != start_total) begin
        ok = 1;
        break;
      end
    end
    if (!ok) n_tmo++;
  endtask

  task automatic wait_words(input int n, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (in_frame && oidx >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) n_tmo++;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (!in_frame) begin
        ok = 1;
        break;
      end
    end
    if (!ok) n_tmo++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; r_valid = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b1;

    // Two back-to-back frames, full throughput, r_valid held across r_finish.
    m_tready = 1'b1; en = 1'b1; r_valid = 1'b1; gap_test = 1;
    wait_finish(200);
    wait_finish(200);
    en = 1'b0; gap_test = 0;

    // Enable low for 20 cycles with a ready buffer, then start and drop en early.
    repeat (20) @(posedge sys_clk);
    #1 en = 1'b1;
    wait_words(3, 200);
    en = 1'b0; r_valid = 1'b0;
    wait_finish(200);

    // Backpressure pattern 1,0,0,1.
    en = 1'b1; r_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      m_tready = (k % 4 == 0) || (k % 4 == 3);
      @(posedge sys_clk);
      #1;
      if (frame_no == 4) break;
    end
    if (frame_no != 4) n_tmo++;
    en = 1'b0; m_tready = 1'b1;
    wait_idle(50);

    // Reset mid-frame, then restart.
    repeat (HOLDOFF + 2) @(posedge sys_clk);
    #1 en = 1'b1; r_valid = 1'b1;
    wait_words(4, 200);
    #1 reset_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 reset_n = 1'b1;
    wait_finish(200);
    en = 1'b0;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      @(posedge sys_clk);
      #1;
      en       = ($urandom_range(0, 3) != 0);
      r_valid  = ($urandom_range(0, 4) != 0);
      m_tready = ($urandom_range(0, 2) != 0);
    end
    en = 1'b0; m_tready = 1'b1;
    wait_idle(500);
    repeat (HOLDOFF + 2) @(posedge sys_clk);

    // frame_cnt wrap from 0xFFFF.
    #1;
    force dut.r_frame_cnt = 16'hFFFF;
    cnt_offset = 16'hFFFF - fin_count;
    @(posedge sys_clk);
    #1 release dut.r_frame_cnt;
    wrap_armed = 1; en = 1'b1; r_valid = 1'b1;
    wait_finish(200);
    en = 1'b0;
    repeat (4) @(posedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
